pc_ship_ctrl: RTL and testbench

- Parametrised player-ship controller: two-axis joystick movement with acceleration ramp, per-axis clamping to a configurable play field, and a life/respawn state machine (explode, hidden wait, blinking invulnerability, game over).
- Updates once per frame on frame_clk_i.
- Feeds ship position/visibility to the sprite renderer and hittable status to the collision unit.

---
 rtl/pc_ship_ctrl_if.sv | 31 +++
 rtl/pc_ship_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_pc_ship_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ship_ctrl_if.sv
// Joystick/event inputs and ship status outputs between game logic and the ship controller.
interface pc_ship_ctrl_if #(
    parameter int unsigned VOL_W = 13,
    parameter int unsigned POS_W = 10
);
    logic [VOL_W-1:0] vol_x_i;
    logic [VOL_W-1:0] vol_y_i;
    logic             hit_i;
    logic             restart_i;
    logic [POS_W-1:0] ship_xpos_o;
    logic [POS_W-1:0] ship_ypos_o;
    logic [POS_W-1:0] ship_size_o;
    logic             ship_visible_o;
    logic             ship_exploding_o;
    logic             ship_alive_o;
    logic [2:0]       lives_o;
    logic             game_over_o;
    logic [2:0]       state_o;

    modport master (
        output vol_x_i, vol_y_i, hit_i, restart_i,
        input  ship_xpos_o, ship_ypos_o, ship_size_o, ship_visible_o,
        input  ship_exploding_o, ship_alive_o, lives_o, game_over_o, state_o
    );

    modport slave (
        input  vol_x_i, vol_y_i, hit_i, restart_i,
        output ship_xpos_o, ship_ypos_o, ship_size_o, ship_visible_o,
        output ship_exploding_o, ship_alive_o, lives_o, game_over_o, state_o
    );
endinterface

// File: rtl/pc_ship_ctrl.sv
// Player ship controller: per-frame joystick movement with acceleration and field clamping,
// plus the life / explode / respawn / invulnerability / game-over sequence.
module pc_ship_ctrl #(
    parameter int unsigned VOL_W          = 13,
    parameter int unsigned POS_W          = 10,
    parameter int unsigned INIT_X         = 304,
    parameter int unsigned INIT_Y         = 400,
    parameter int unsigned MIN_X          = 133,
    parameter int unsigned MAX_X          = 506,
    parameter int unsigned MIN_Y          = 240,
    parameter int unsigned MAX_Y          = 479,
    parameter int unsigned SIZE           = 16,
    parameter int unsigned THRESH_HI      = 13'h0800,
    parameter int unsigned THRESH_LO      = 13'h0500,
    parameter int unsigned MAX_SPEED      = 4,
    parameter int unsigned ACCEL_FRAMES   = 4,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned EXPLODE_FRAMES = 32,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned INVULN_FRAMES  = 120,
    parameter int unsigned BLINK_SHIFT    = 3
) (
    input logic           frame_clk_i,
    input logic           reset_i,
    pc_ship_ctrl_if.slave bus
);
    localparam int unsigned HOLD_CAP = ACCEL_FRAMES * (MAX_SPEED - 1);
    localparam int unsigned HOLD_W   = $clog2(HOLD_CAP + 2);
    localparam int unsigned SPD_W    = $clog2(MAX_SPEED + 1);
    localparam int unsigned T_MAX1   = (EXPLODE_FRAMES > RESPAWN_FRAMES) ? EXPLODE_FRAMES : RESPAWN_FRAMES;
    localparam int unsigned T_MAX    = (T_MAX1 > INVULN_FRAMES) ? T_MAX1 : INVULN_FRAMES;
    localparam int unsigned TMR_W    = $clog2(T_MAX + 1);
    localparam int unsigned BLK_W    = BLINK_SHIFT + 1;
    localparam int unsigned EXT_W    = POS_W + 1;

    typedef enum logic [2:0] {
        ST_ALIVE     = 3'd0,
        ST_EXPLODE   = 3'd1,
        ST_RESPAWN   = 3'd2,
        ST_INVULN    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_POS  = 2'd1,
        DIR_NEG  = 2'd2
    } dir_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [BLK_W-1:0]   blink_q, blink_d;
    logic [2:0]         lives_q, lives_d;
    logic [POS_W-1:0]   xpos_q, xpos_d, ypos_q, ypos_d;
    dir_e               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [HOLD_W-1:0]  hold_x_q, hold_x_d, hold_y_q, hold_y_d;
    dir_e               dir_x, dir_y;
    logic [SPD_W-1:0]   spd_x, spd_y;
    logic               move_en, respawn;

    function automatic dir_e vol_dir(input logic [VOL_W-1:0] vol);
        if (vol > VOL_W'(THRESH_HI)) return DIR_NEG;
        if (vol < VOL_W'(THRESH_LO)) return DIR_POS;
        return DIR_NONE;
    endfunction

    // Speed ramps by one every ACCEL_FRAMES held frames; any change of direction restarts at 1.
    function automatic logic [SPD_W-1:0] axis_spd(input dir_e dir, input dir_e prev,
                                                  input logic [HOLD_W-1:0] hold);
        int unsigned s;
        if (dir == DIR_NONE) return '0;
        if (dir != prev) return SPD_W'(1);
        s = 32'(hold) / ACCEL_FRAMES + 1;
        if (s > MAX_SPEED) s = MAX_SPEED;
        return SPD_W'(s);
    endfunction

    function automatic logic [HOLD_W-1:0] axis_hold(input dir_e dir, input dir_e prev,
                                                    input logic [HOLD_W-1:0] hold);
        if (dir == DIR_NONE) return '0;
        if (dir != prev) return HOLD_W'(1);
        if (32'(hold) >= HOLD_CAP) return hold;
        return hold + HOLD_W'(1);
    endfunction

    // One extra bit keeps the sums from wrapping before the bound comparison.
    function automatic logic [POS_W-1:0] axis_pos(input logic [POS_W-1:0] pos, input dir_e dir,
                                                  input logic [SPD_W-1:0] spd,
                                                  input int unsigned lo, input int unsigned hi);
        logic [EXT_W-1:0] p, s;
        p = EXT_W'(pos);
        s = EXT_W'(spd);
        case (dir)
            DIR_NEG: return (p < EXT_W'(lo) + s) ? POS_W'(lo) : POS_W'(p - s);
            DIR_POS: return (p + s + EXT_W'(SIZE) > EXT_W'(hi)) ? POS_W'(hi - SIZE) : POS_W'(p + s);
            default: return pos;
        endcase
    endfunction

    always_ff @(posedge frame_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_ALIVE;
            timer_q  <= '0;
            blink_q  <= '0;
            lives_q  <= 3'(LIVES);
            xpos_q   <= POS_W'(INIT_X);
            ypos_q   <= POS_W'(INIT_Y);
            dir_x_q  <= DIR_NONE;
            dir_y_q  <= DIR_NONE;
            hold_x_q <= '0;
            hold_y_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            blink_q  <= blink_d;
            lives_q  <= lives_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            hold_x_q <= hold_x_d;
            hold_y_q <= hold_y_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        blink_d  = '0;
        lives_d  = lives_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        dir_x_d  = DIR_NONE;
        dir_y_d  = DIR_NONE;
        hold_x_d = '0;
        hold_y_d = '0;
        move_en  = 1'b0;
        respawn  = 1'b0;
        dir_x    = vol_dir(bus.vol_x_i);
        dir_y    = vol_dir(bus.vol_y_i);
        spd_x    = '0;
        spd_y    = '0;

        case (state_q)
            ST_ALIVE: begin
                if (bus.hit_i) begin
                    state_d = ST_EXPLODE;
                    lives_d = lives_q - 3'd1;
                end else begin
                    move_en = 1'b1;
                end
            end
            ST_EXPLODE: begin
                timer_d = timer_q + TMR_W'(1);
                if (timer_q == TMR_W'(EXPLODE_FRAMES - 1)) begin
                    timer_d = '0;
                    state_d = (lives_q == 3'd0) ? ST_GAME_OVER : ST_RESPAWN;
                end
            end
            ST_RESPAWN: begin
                timer_d = timer_q + TMR_W'(1);
                if (timer_q == TMR_W'(RESPAWN_FRAMES - 1)) begin
                    timer_d = '0;
                    state_d = ST_INVULN;
                    respawn = 1'b1;
                end
            end
            ST_INVULN: begin
                move_en = 1'b1;
                timer_d = timer_q + TMR_W'(1);
                blink_d = blink_q + BLK_W'(1);
                if (timer_q == TMR_W'(INVULN_FRAMES - 1)) begin
                    timer_d = '0;
                    blink_d = '0;
                    state_d = ST_ALIVE;
                end
            end
            ST_GAME_OVER: begin
                if (bus.restart_i) begin
                    state_d = ST_INVULN;
                    lives_d = 3'(LIVES);
                    respawn = 1'b1;
                end
            end
            default: state_d = ST_ALIVE;
        endcase

        if (move_en) begin
            spd_x    = axis_spd(dir_x, dir_x_q, hold_x_q);
            spd_y    = axis_spd(dir_y, dir_y_q, hold_y_q);
            hold_x_d = axis_hold(dir_x, dir_x_q, hold_x_q);
            hold_y_d = axis_hold(dir_y, dir_y_q, hold_y_q);
            dir_x_d  = dir_x;
            dir_y_d  = dir_y;
            xpos_d   = axis_pos(xpos_q, dir_x, spd_x, MIN_X, MAX_X);
            ypos_d   = axis_pos(ypos_q, dir_y, spd_y, MIN_Y, MAX_Y);
        end

        if (respawn) begin
            xpos_d = POS_W'(INIT_X);
            ypos_d = POS_W'(INIT_Y);
        end
    end

    assign bus.ship_xpos_o      = xpos_q;
    assign bus.ship_ypos_o      = ypos_q;
    assign bus.ship_size_o      = POS_W'(SIZE);
    assign bus.ship_visible_o   = (state_q == ST_ALIVE) || (state_q == ST_EXPLODE) ||
                                  ((state_q == ST_INVULN) && !blink_q[BLINK_SHIFT]);
    assign bus.ship_exploding_o = (state_q == ST_EXPLODE);
    assign bus.ship_alive_o     = (state_q == ST_ALIVE);
    assign bus.lives_o          = lives_q;
    assign bus.game_over_o      = (state_q == ST_GAME_OVER);
    assign bus.state_o          = state_q;
endmodule

// File: tb/tb_pc_ship_ctrl.sv
// Randomised bench for pc_ship_ctrl against a frame-level behavioural model of the ship.
module tb_pc_ship_ctrl;
    localparam int unsigned VOL_W = 13;
    localparam int unsigned POS_W = 10;
    localparam int NEUTRAL = 'h600;
    localparam int LEFT    = 'h900;
    localparam int RIGHT   = 'h100;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    pc_ship_ctrl_if #(.VOL_W(VOL_W), .POS_W(POS_W)) bus ();
    pc_ship_ctrl dut (.frame_clk_i(clk), .reset_i(rst), .bus(bus));

    always #5 clk = ~clk;

    // Model: state code, position, lives, frames spent in current state, per-axis direction runs.
    int m_state, m_x, m_y, m_lives, m_t;
    int m_dx, m_dy, m_rx, m_ry;
    string fld [8] = '{"state", "xpos", "ypos", "lives", "visible", "exploding", "alive", "game_over"};

    function automatic int dir_of(input int v);
        if (v > 'h800) return -1;
        if (v < 'h500) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_x = 304; m_y = 400; m_lives = 3; m_t = 0;
        m_dx = 0; m_dy = 0; m_rx = 0; m_ry = 0;
    endtask

    task automatic axis_move(input int d, inout int pos, inout int prev, inout int run,
                             input int lo, input int hi);
        int spd;
        if (d != prev) run = 0;
        spd = (d == 0) ? 0 : ((1 + run / 4 < 4) ? 1 + run / 4 : 4);
        run++;
        prev = d;
        pos = pos + d * spd;
        if (pos < lo) pos = lo;
        if (pos + 16 > hi) pos = hi - 16;
    endtask

    task automatic model_edge(input int vx, input int vy, input bit hit, input bit rs);
        int ns;
        ns = m_state;
        if ((m_state == 0 && !hit) || m_state == 3) begin
            axis_move(dir_of(vx), m_x, m_dx, m_rx, 133, 506);
            axis_move(dir_of(vy), m_y, m_dy, m_ry, 240, 479);
        end else begin
            m_dx = 0; m_dy = 0; m_rx = 0; m_ry = 0;
        end
        m_t++;
        case (m_state)
            0: if (hit) begin ns = 1; m_lives--; end
            1: if (m_t == 32) ns = (m_lives == 0) ? 4 : 2;
            2: if (m_t == 60) begin ns = 3; m_x = 304; m_y = 400; end
            3: if (m_t == 120) ns = 0;
            4: if (rs) begin ns = 3; m_lives = 3; m_x = 304; m_y = 400; end
            default: ns = 0;
        endcase
        if (ns != m_state) m_t = 0;
        m_state = ns;
    endtask

    function automatic int exp_visible();
        case (m_state)
            0, 1: return 1;
            3:    return ((m_t / 8) % 2 == 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic frame(input int vx, input int vy, input bit hit, input bit rs);
        bus.vol_x_i = VOL_W'(vx);
        bus.vol_y_i = VOL_W'(vy);
        bus.hit_i = hit;
        bus.restart_i = rs;
        @(posedge clk);
        model_edge(vx, vy, hit, rs);
        #1;
        bus.hit_i = 1'b0;
        bus.restart_i = 1'b0;
    endtask

    // Random joystick run with optional hit/restart noise, every output compared to the model.
    task automatic test_random_run(input int max_frames, input int stop_state, input int ev_rate);
        int vx, vy, hold_left, got[8], exp_v[8];
        bit hit, rs, reached;
        vx = NEUTRAL; vy = NEUTRAL; hold_left = 0; reached = 0;
        for (int f = 0; f < max_frames && !reached; f++) begin
            if (hold_left == 0) begin
                vx = int'($urandom_range(0, 8191));
                vy = int'($urandom_range(0, 8191));
                hold_left = int'($urandom_range(1, 12));
            end
            hold_left--;
            hit = (ev_rate > 0) && ($urandom_range(0, ev_rate - 1) == 0);
            rs  = (ev_rate > 0) && ($urandom_range(0, ev_rate - 1) == 0);
            frame(vx, vy, hit, rs);
            got   = '{int'(bus.state_o), int'(bus.ship_xpos_o), int'(bus.ship_ypos_o), int'(bus.lives_o),
                      int'(bus.ship_visible_o), int'(bus.ship_exploding_o), int'(bus.ship_alive_o),
                      int'(bus.game_over_o)};
            exp_v = '{m_state, m_x, m_y, m_lives, exp_visible(), int'(m_state == 1), int'(m_state == 0),
                      int'(m_state == 4)};
            for (int k = 0; k < 8; k++) begin
                n_chk++;
                if (got[k] !== exp_v[k]) begin
                    n_fail++;
                    $display("FAIL %s frame %0d: got %0d expected %0d", fld[k], f, got[k], exp_v[k]);
                end
            end
            reached = (m_state == stop_state);
        end
        if (stop_state >= 0) begin
            n_chk++;
            if (!reached) begin
                n_fail++;
                $display("FAIL timeout waiting for state %0d: got %0d", stop_state, bus.state_o);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.vol_x_i = VOL_W'(NEUTRAL); bus.vol_y_i = VOL_W'(NEUTRAL);
        bus.hit_i = 1'b0; bus.restart_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_chk += 4;
        if (bus.ship_xpos_o !== 10'd304 || bus.ship_ypos_o !== 10'd400) begin
            n_fail++; $display("FAIL reset_pos: got (%0d,%0d) expected (304,400)", bus.ship_xpos_o, bus.ship_ypos_o);
        end
        if (bus.lives_o !== 3'd3 || bus.state_o !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got lives %0d state %0d expected 3 0", bus.lives_o, bus.state_o);
        end
        if (bus.ship_visible_o !== 1'b1 || bus.ship_alive_o !== 1'b1 || bus.ship_exploding_o !== 1'b0
            || bus.game_over_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got vis %b alive %b expl %b go %b expected 1 1 0 0",
                               bus.ship_visible_o, bus.ship_alive_o, bus.ship_exploding_o, bus.game_over_o);
        end
        if (bus.ship_size_o !== 10'd16) begin
            n_fail++; $display("FAIL size: got %0d expected 16", bus.ship_size_o);
        end
    endtask

    task automatic test_accel();
        int tab[13] = '{303, 302, 301, 300, 298, 296, 294, 292, 289, 286, 283, 280, 276};
        for (int i = 0; i < 13; i++) begin
            frame(LEFT, NEUTRAL, 0, 0);
            n_chk++;
            if (bus.ship_xpos_o !== POS_W'(tab[i])) begin
                n_fail++; $display("FAIL accel step %0d: got %0d expected %0d", i, bus.ship_xpos_o, tab[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            frame(NEUTRAL, NEUTRAL, 0, 0);
            n_chk++;
            if (bus.ship_xpos_o !== 10'd276) begin
                n_fail++; $display("FAIL release hold: got %0d expected 276", bus.ship_xpos_o);
            end
        end
        frame(LEFT, NEUTRAL, 0, 0);
        n_chk++;
        if (bus.ship_xpos_o !== 10'd275) begin
            n_fail++; $display("FAIL repush speed: got %0d expected 275", bus.ship_xpos_o);
        end
    endtask

    task automatic test_clamp();
        int vx[4] = '{LEFT, RIGHT, NEUTRAL, NEUTRAL};
        int vy[4] = '{NEUTRAL, NEUTRAL, LEFT, RIGHT};
        int lim[4] = '{133, 490, 240, 463};
        int got;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 120; i++) begin
                frame(vx[s], vy[s], 0, 0);
                got = (s < 2) ? int'(bus.ship_xpos_o) : int'(bus.ship_ypos_o);
                n_chk++;
                if (got !== ((s < 2) ? m_x : m_y)) begin
                    n_fail++; $display("FAIL clamp track %0d/%0d: got %0d expected %0d", s, i, got,
                                       (s < 2) ? m_x : m_y);
                end
            end
            n_chk++;
            if (got !== lim[s]) begin
                n_fail++; $display("FAIL clamp bound %0d: got %0d expected %0d", s, got, lim[s]);
            end
        end
    endtask

    task automatic test_random();
        test_random_run(300, -1, 0);
    endtask

    task automatic test_life();
        int cnt[8], blank;
        bit first_inv;
        cnt = '{default: 0}; blank = 0; first_inv = 1;
        frame(LEFT, LEFT, 1, 0);
        n_chk++;
        if (bus.state_o !== 3'd1 || bus.lives_o !== 3'd2 || bus.ship_exploding_o !== 1'b1
            || bus.ship_alive_o !== 1'b0 || bus.ship_xpos_o !== POS_W'(m_x)) begin
            n_fail++; $display("FAIL hit entry: got state %0d lives %0d expl %b x %0d expected 1 2 1 %0d",
                               bus.state_o, bus.lives_o, bus.ship_exploding_o, bus.ship_xpos_o, m_x);
        end
        for (int f = 0; f < 400 && m_state != 0; f++) begin
            frame(int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            if (m_state == 0) break;
            cnt[bus.state_o]++;
            if (bus.state_o == 3'd3 && !bus.ship_visible_o) blank++;
            n_chk++;
            if (bus.state_o !== 3'(m_state) || bus.ship_xpos_o !== POS_W'(m_x) || bus.ship_ypos_o !== POS_W'(m_y)
                || bus.ship_visible_o !== 1'(exp_visible())) begin
                n_fail++; $display("FAIL life frame %0d: got st %0d (%0d,%0d) vis %b expected st %0d (%0d,%0d) vis %0d",
                                   f, bus.state_o, bus.ship_xpos_o, bus.ship_ypos_o, bus.ship_visible_o,
                                   m_state, m_x, m_y, exp_visible());
            end
            if (first_inv && m_state == 3 && m_t == 0) begin
                first_inv = 0;
                n_chk++;
                if (bus.ship_xpos_o !== 10'd304 || bus.ship_ypos_o !== 10'd400) begin
                    n_fail++; $display("FAIL respawn pos: got (%0d,%0d) expected (304,400)",
                                       bus.ship_xpos_o, bus.ship_ypos_o);
                end
            end
        end
        n_chk++;
        if (cnt[1] !== 31 || cnt[2] !== 60 || cnt[3] !== 120 || blank !== 56 || bus.state_o !== 3'd0) begin
            n_fail++; $display("FAIL life durations: got expl %0d resp %0d inv %0d blank %0d end %0d expected 31 60 120 56 0",
                               cnt[1], cnt[2], cnt[3], blank, bus.state_o);
        end
    endtask

    task automatic test_game_over();
        frame(RIGHT, NEUTRAL, 1, 0);
        test_random_run(400, 0, 4);
        frame(NEUTRAL, RIGHT, 1, 0);
        test_random_run(100, 4, 4);
        n_chk++;
        if (bus.state_o !== 3'd4 || bus.game_over_o !== 1'b1 || bus.ship_visible_o !== 1'b0 || bus.lives_o !== 3'd0) begin
            n_fail++; $display("FAIL game_over: got st %0d go %b vis %b lives %0d expected 4 1 0 0",
                               bus.state_o, bus.game_over_o, bus.ship_visible_o, bus.lives_o);
        end
        for (int i = 0; i < 5; i++) begin
            frame(LEFT, LEFT, 1, 0);
            n_chk++;
            if (bus.state_o !== 3'd4 || bus.ship_xpos_o !== POS_W'(m_x) || bus.ship_ypos_o !== POS_W'(m_y)) begin
                n_fail++; $display("FAIL game_over hold: got st %0d (%0d,%0d) expected 4 (%0d,%0d)",
                                   bus.state_o, bus.ship_xpos_o, bus.ship_ypos_o, m_x, m_y);
            end
        end
        frame(LEFT, LEFT, 0, 1);
        n_chk++;
        if (bus.state_o !== 3'd3 || bus.lives_o !== 3'd3 || bus.ship_xpos_o !== 10'd304
            || bus.ship_ypos_o !== 10'd400 || bus.game_over_o !== 1'b0) begin
            n_fail++; $display("FAIL restart: got st %0d lives %0d (%0d,%0d) go %b expected 3 3 (304,400) 0",
                               bus.state_o, bus.lives_o, bus.ship_xpos_o, bus.ship_ypos_o, bus.game_over_o);
        end
    endtask

    task automatic test_async_reset();
        test_random_run(200, 0, 0);
        repeat (6) frame(LEFT, LEFT, 0, 0);
        frame(NEUTRAL, NEUTRAL, 1, 0);
        repeat (5) frame(NEUTRAL, NEUTRAL, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.state_o !== 3'd0 || bus.lives_o !== 3'd3 || bus.ship_xpos_o !== 10'd304 || bus.ship_ypos_o !== 10'd400
            || bus.ship_visible_o !== 1'b1 || bus.ship_alive_o !== 1'b1 || bus.ship_exploding_o !== 1'b0) begin
            n_fail++; $display("FAIL async reset: got st %0d lives %0d (%0d,%0d) vis %b alive %b expl %b",
                               bus.state_o, bus.lives_o, bus.ship_xpos_o, bus.ship_ypos_o,
                               bus.ship_visible_o, bus.ship_alive_o, bus.ship_exploding_o);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        test_random_run(20, -1, 0);
    endtask

    initial begin
        test_reset();
        test_accel();
        test_clamp();
        test_random();
        test_life();
        test_game_over();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
